rf_multiport_sb: RTL
====================

// Module: rf_multiport_sb
// PURPOSE
//  Parametrised multi-port integer register file with a per-register busy/tag scoreboard.
//  - Write-to-read bypass, negated read outputs and optional hardwired-zero r0.
//  - Sits between issue (allocates destination tags) and writeback (commits results).
//  - Gives issue logic operand data plus a ready flag per read port.
// PARAMETERS
//  ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH
//  DATA_WIDTH  32  register data width
//  NUM_RD      4   number of read ports
//  NUM_WR      2   number of write ports (= number of issue ports)
//  TAG_WIDTH   4   producer tag width
//  ZERO_REG    1   1: register 0 reads 0 and ignores writes and issues
// PORTS
//  clk        in   1                    clock, all state on rising edge
//  rst        in   1                    asynchronous reset, active-high
//  raddr      in   NUM_RD*ADDR_WIDTH    read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  rdata      out  NUM_RD*DATA_WIDTH    read data (combinational, bypassed)
//  rdata_n    out  NUM_RD*DATA_WIDTH    two's-complement negation of rdata, mod 2**DATA_WIDTH
//  rbusy      out  NUM_RD               1 = operand still pending (not ready)
//  we         in   NUM_WR               write enables
//  waddr      in   NUM_WR*ADDR_WIDTH    write addresses
//  wdata      in   NUM_WR*DATA_WIDTH    write data
//  wtag       in   NUM_WR*TAG_WIDTH     producer tag carried by each write
//  iss_valid  in   NUM_WR               destination allocation strobes
//  iss_addr   in   NUM_WR*ADDR_WIDTH    destination registers being allocated
//  iss_tag    in   NUM_WR*TAG_WIDTH     tag of new producer
//  flush      in   1                    clear whole scoreboard
//  busy_cnt   out  ADDR_WIDTH+1         registered count of busy registers
// BEHAVIOUR
//  Reset (async, while rst=1): all registers 0, all busy 0, all tags 0, busy_cnt 0.
//  Read, combinational:
//   - rdata = value of the highest-index write port with we=1 and a matching waddr; else rf[raddr].
//   - ZERO_REG=1 and raddr=0: rdata=0 and rbusy=0, regardless of writes.
//  rbusy[i] = busy[raddr_i] AND NOT (any port j: we_j, waddr_j==raddr_i, wtag_j==tag[raddr_i]).
//   A matching writeback makes the operand ready in the same cycle.
//  Write, at posedge:
//   - rf[waddr_j] <= wdata_j for every port with we_j=1.
//   - Same address on several ports: the highest index wins.
//   - The write commits whether or not the tag matches; the tag affects only the scoreboard.
//   - ZERO_REG=1: writes to r0 are dropped.
//  Scoreboard update at posedge, per register r, applied in order:
//   1. Clear: busy[r] <= 0 if busy[r] and some we_j with waddr_j==r carries wtag_j==tag[r].
//      A stale tag does not clear.
//   2. Set: if iss_valid_k and iss_addr_k==r then busy[r] <= 1 and tag[r] <= iss_tag_k.
//      Set overrides clear on the same register.
//      Several issue ports on one register: the highest index wins.
//      ZERO_REG=1: issues to r0 are ignored.
//   3. flush=1: all busy <= 0 and all issues that cycle are ignored. Writes still commit; tags hold.
//  busy_cnt: popcount of the next busy vector, registered.
//   - Always equals the number of set busy bits; ranges 0..2**ADDR_WIDTH.
//  Latency:
//   - Read and bypass: 0 cycles.
//   - Write visible through rf: next cycle.
//   - Issue sets rbusy: next cycle.
//  Reset asserted mid-operation clears state immediately; writes and issues in that cycle are lost.
// TESTING
//  1. Reset, then read all ports at r5 -> rdata=0, rdata_n=0, rbusy=0, busy_cnt=0.
//  2. Issue r3 tag 7; next cycle write r3=0x10 tag 7 -> rbusy=0 in the write cycle,
//     rdata=0x10, rdata_n=0xFFFFFFF0; busy_cnt 1 -> 0.
//  3. Issue r3 tag 2, then issue r3 tag 5, then write r3 tag 2 -> data written;
//     r3 stays busy; write tag 5 clears it.
//  4. Ports 0 and 1 both write r9 (0xA, 0xB) -> rdata=0xB bypassed, and rf[r9]=0xB next cycle.
//  5. Write r0=0x55 and issue r0 -> rdata(r0)=0, rbusy=0, busy_cnt unchanged.
//  6. Issue r1, r2, r4, then flush together with an issue of r6 -> busy_cnt 3 -> 0 and r6 not busy.
//     Then assert rst mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rf_multiport_sb_if.sv
// Bundle of read, writeback, issue and scoreboard status signals for rf_multiport_sb.
// The master side (issue/writeback logic) drives addresses and strobes; the slave side is the register file.
interface rf_multiport_sb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int TAG_WIDTH  = 4
);
    logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
    logic [NUM_RD*DATA_WIDTH-1:0] rdata;
    logic [NUM_RD*DATA_WIDTH-1:0] rdata_n;
    logic [NUM_RD-1:0]            rbusy;
    logic [NUM_WR-1:0]            we;
    logic [NUM_WR*ADDR_WIDTH-1:0] waddr;
    logic [NUM_WR*DATA_WIDTH-1:0] wdata;
    logic [NUM_WR*TAG_WIDTH-1:0]  wtag;
    logic [NUM_WR-1:0]            iss_valid;
    logic [NUM_WR*ADDR_WIDTH-1:0] iss_addr;
    logic [NUM_WR*TAG_WIDTH-1:0]  iss_tag;
    logic                         flush;
    logic [ADDR_WIDTH:0]          busy_cnt;

    modport master (
        output raddr, we, waddr, wdata, wtag, iss_valid, iss_addr, iss_tag, flush,
        input  rdata, rdata_n, rbusy, busy_cnt
    );

    modport slave (
        input  raddr, we, waddr, wdata, wtag, iss_valid, iss_addr, iss_tag, flush,
        output rdata, rdata_n, rbusy, busy_cnt
    );
endinterface

// File: rtl/rf_multiport_sb.sv
// Multi-port register file with write-to-read bypass and a per-register busy/tag scoreboard.
// Read ports report operand data, its negation, and whether the producer is still outstanding.
module rf_multiport_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int TAG_WIDTH  = 4,
    parameter int ZERO_REG   = 1
) (
    input logic              clk,
    input logic              rst,
    rf_multiport_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf      [DEPTH];
    logic [TAG_WIDTH-1:0]  tag     [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_nxt [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;
    logic [ADDR_WIDTH:0]   cnt_nxt;
    logic [ADDR_WIDTH:0]   cnt_q;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  rd_hit;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Bypass is suppressed during reset so the outputs show reset values while writes are being dropped.
    always_comb begin
        bus.rdata   = '0;
        bus.rdata_n = '0;
        bus.rbusy   = '0;
        rd_addr     = '0;
        rd_val      = '0;
        rd_hit      = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rd_val  = rf[rd_addr];
            rd_hit  = 1'b0;
            if (!rst) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.we[j] && bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr) begin
                        rd_val = bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
                        if (bus.wtag[j*TAG_WIDTH +: TAG_WIDTH] == tag[rd_addr])
                            rd_hit = 1'b1;
                    end
                end
            end
            if (is_zero(rd_addr)) begin
                rd_val       = '0;
                bus.rbusy[i] = 1'b0;
            end else begin
                bus.rbusy[i] = busy[rd_addr] & ~rd_hit;
            end
            bus.rdata[i*DATA_WIDTH +: DATA_WIDTH]   = rd_val;
            bus.rdata_n[i*DATA_WIDTH +: DATA_WIDTH] = -rd_val;
        end
    end

    // Clear on matching tag, then issue (later ports win), then flush overrides everything but tags.
    always_comb begin
        busy_nxt = busy;
        tag_nxt  = tag;
        cnt_nxt  = '0;
        for (int r = 0; r < DEPTH; r++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.we[j] && bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)
                    && bus.wtag[j*TAG_WIDTH +: TAG_WIDTH] == tag[r])
                    busy_nxt[r] = 1'b0;
            end
            if (!bus.flush && !is_zero(ADDR_WIDTH'(r))) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (bus.iss_valid[k] && bus.iss_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                        busy_nxt[r] = 1'b1;
                        tag_nxt[r]  = bus.iss_tag[k*TAG_WIDTH +: TAG_WIDTH];
                    end
                end
            end
            if (bus.flush)
                busy_nxt[r] = 1'b0;
            cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[r]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                rf[r]  <= '0;
                tag[r] <= '0;
            end
            busy  <= '0;
            cnt_q <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.we[j] && !is_zero(bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH]))
                    rf[bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int r = 0; r < DEPTH; r++)
                tag[r] <= tag_nxt[r];
            busy  <= busy_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    assign bus.busy_cnt = cnt_q;
endmodule
